// File: rtl/clock_pkg.sv
// Shared time-word layout, field limits, field-select codes and the edit FSM states
// for the clock datapath: {hour[4:0], min[5:0], sec[5:0]}.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int TIME_W = 17;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

    localparam logic [1:0] FIELD_NONE = 2'b00;
    localparam logic [1:0] FIELD_HOUR = 2'b01;
    localparam logic [1:0] FIELD_MIN  = 2'b10;
    localparam logic [1:0] FIELD_SEC  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EDIT_HOUR = 3'd1,
        ST_EDIT_MIN  = 3'd2,
        ST_EDIT_SEC  = 3'd3,
        ST_COMMIT    = 3'd4
    } state_t;

    // Any field outside its legal range becomes 0 so an edit never starts illegal.
    function automatic logic [TIME_W-1:0] sanitize_time(input logic [TIME_W-1:0] t);
        logic [HOUR_W-1:0] h;
        logic [MIN_W-1:0]  m;
        logic [SEC_W-1:0]  s;
        h = t[TIME_W-1 -: HOUR_W];
        m = t[SEC_W +: MIN_W];
        s = t[SEC_W-1:0];
        if (h > HOUR_W'(HOUR_MAX)) h = '0;
        if (m > MIN_W'(MIN_MAX))   m = '0;
        if (s > SEC_W'(SEC_MAX))   s = '0;
        return {h, m, s};
    endfunction

endpackage

// File: rtl/time_setter_wrap_step.sv
// Modular +1/-1 stepper for one time field; inc and dec together leave the value alone.
module wrap_step #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic [W-1:0] value,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] next_value
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_comb begin
        next_value = value;
        if (inc && !dec) begin
            next_value = (value == MAX_V) ? '0 : value + 1'b1;
        end else if (dec && !inc) begin
            next_value = (value == '0) ? MAX_V : value - 1'b1;
        end
    end

endmodule

// File: rtl/time_setter.sv
// Time-edit controller upstream of clockWork: capture, step fields, one-cycle overwrite strobe.
// Optional inactivity abort is built when EDIT_TIMEOUT_EN is defined.
module time_setter
    import clock_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_mode,
    input  logic                btn_inc,
    input  logic                btn_dec,
    input  logic                btn_cancel,
    input  logic [TIME_W-1:0]   time_cur,
    output logic [TIME_W-1:0]   time_set,
    output logic                time_ow,
    output logic                editing,
    output logic [1:0]          field_sel,
    output logic [2:0]          state_dbg
);

    // Buttons are single-cycle pulses sampled on the rising edge; no handshake, no queuing.
    state_t state, state_next;

    logic [HOUR_W-1:0] hour_q, hour_step;
    logic [MIN_W-1:0]  min_q,  min_step;
    logic [SEC_W-1:0]  sec_q,  sec_step;

    logic in_edit;
    logic any_btn;
    logic timeout_hit;

    assign in_edit   = (state == ST_EDIT_HOUR) || (state == ST_EDIT_MIN) || (state == ST_EDIT_SEC);
    assign any_btn   = btn_mode | btn_inc | btn_dec | btn_cancel;
    assign time_set  = {hour_q, min_q, sec_q};
    assign state_dbg = state;

`ifdef EDIT_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if ((state == ST_IDLE && btn_mode) || (in_edit && any_btn)) begin
            idle_cnt <= '0;
        end else if (in_edit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout_hit = in_edit && !any_btn && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout the edit persists; the term is constant false for any sane parameter.
    assign timeout_hit = (TIMEOUT_CYCLES < 1) && in_edit && !any_btn;
`endif

    wrap_step #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .value      (hour_q),
        .inc        (btn_inc && state == ST_EDIT_HOUR),
        .dec        (btn_dec && state == ST_EDIT_HOUR),
        .next_value (hour_step)
    );

    wrap_step #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .value      (min_q),
        .inc        (btn_inc && state == ST_EDIT_MIN),
        .dec        (btn_dec && state == ST_EDIT_MIN),
        .next_value (min_step)
    );

    wrap_step #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .value      (sec_q),
        .inc        (btn_inc && state == ST_EDIT_SEC),
        .dec        (btn_dec && state == ST_EDIT_SEC),
        .next_value (sec_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Mode and cancel both suppress the step, so a field only moves on a lone inc/dec.
    always_ff @(posedge clk) begin
        if (rst) begin
            hour_q <= '0;
            min_q  <= '0;
            sec_q  <= '0;
        end else if (state == ST_IDLE && btn_mode) begin
            {hour_q, min_q, sec_q} <= sanitize_time(time_cur);
        end else if (in_edit && !btn_cancel && !btn_mode) begin
            hour_q <= hour_step;
            min_q  <= min_step;
            sec_q  <= sec_step;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (btn_mode) state_next = ST_EDIT_HOUR;
            end
            ST_EDIT_HOUR: begin
                if (btn_cancel)       state_next = ST_IDLE;
                else if (btn_mode)    state_next = ST_EDIT_MIN;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_EDIT_MIN: begin
                if (btn_cancel)       state_next = ST_IDLE;
                else if (btn_mode)    state_next = ST_EDIT_SEC;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_EDIT_SEC: begin
                if (btn_cancel)       state_next = ST_IDLE;
                else if (btn_mode)    state_next = ST_COMMIT;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        time_ow   = 1'b0;
        editing   = 1'b0;
        field_sel = FIELD_NONE;
        case (state)
            ST_EDIT_HOUR: begin editing = 1'b1; field_sel = FIELD_HOUR; end
            ST_EDIT_MIN:  begin editing = 1'b1; field_sel = FIELD_MIN;  end
            ST_EDIT_SEC:  begin editing = 1'b1; field_sel = FIELD_SEC;  end
            ST_COMMIT:    time_ow = 1'b1;
            default:      ;
        endcase
    end

endmodule

// File: tb/tb_time_setter.sv
// Self-checking bench for time_setter; the timeout scenario is built when EDIT_TIMEOUT_EN is defined.
module tb_time_setter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0;
    logic [16:0] time_cur = '0;
    logic [16:0] time_set;
    logic        time_ow, editing;
    logic [1:0]  field_sel;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_fail = 0;
    int strobe_cnt = 0;
    logic [16:0] exp_q[$];

    time_setter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_cancel(btn_cancel), .time_cur(time_cur), .time_set(time_set), .time_ow(time_ow),
        .editing(editing), .field_sel(field_sel), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input int h, input int m, input int s);
        logic [4:0] hh;
        logic [5:0] mm, ss;
        hh = h[4:0];
        mm = m[5:0];
        ss = s[5:0];
        return {hh, mm, ss};
    endfunction

    // Pulse buttons for exactly one rising edge; returns at the following falling edge.
    task automatic press(input logic m, input logic i, input logic d, input logic c);
        btn_mode = m; btn_inc = i; btn_dec = d; btn_cancel = c;
        @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_cancel = 1'b0;
    endtask

    // Scoreboard: every strobe must match the oldest expected commit word.
    always @(negedge clk) begin
        if (!rst && time_ow) begin
            logic [16:0] e;
            strobe_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: got time_ow=1 time_set=%h, required no strobe", time_set);
            end else begin
                e = exp_q.pop_front();
                if (time_set !== e) begin
                    n_fail++;
                    $display("FAIL commit_word: got %h required %h", time_set, e);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (time_set !== 17'd0) begin n_fail++; $display("FAIL rst_time_set: got %h required 0", time_set); end
        n_cmp++; if (time_ow !== 1'b0) begin n_fail++; $display("FAIL rst_time_ow: got %b required 0", time_ow); end
        n_cmp++; if (editing !== 1'b0) begin n_fail++; $display("FAIL rst_editing: got %b required 0", editing); end
        n_cmp++; if (field_sel !== 2'b00) begin n_fail++; $display("FAIL rst_field_sel: got %b required 00", field_sel); end
        n_cmp++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d required 0", state_dbg); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_capture_and_hour_wrap();
        time_cur = 17'b10111_110000_000000;
        press(1, 0, 0, 0);
        n_cmp++; if (editing !== 1'b1) begin n_fail++; $display("FAIL cap_editing: got %b required 1", editing); end
        n_cmp++; if (field_sel !== 2'b01) begin n_fail++; $display("FAIL cap_field: got %b required 01", field_sel); end
        n_cmp++; if (time_set !== mk(23, 48, 0)) begin n_fail++; $display("FAIL cap_time: got %h required %h", time_set, mk(23, 48, 0)); end
        n_cmp++; if (time_ow !== 1'b0) begin n_fail++; $display("FAIL cap_ow: got %b required 0", time_ow); end
        press(0, 1, 0, 0);
        n_cmp++; if (time_set !== mk(0, 48, 0)) begin n_fail++; $display("FAIL hour_inc_wrap: got %h required %h", time_set, mk(0, 48, 0)); end
        press(0, 0, 1, 0);
        n_cmp++; if (time_set !== mk(23, 48, 0)) begin n_fail++; $display("FAIL hour_dec_wrap: got %h required %h", time_set, mk(23, 48, 0)); end
        press(0, 1, 1, 0);
        n_cmp++; if (time_set !== mk(23, 48, 0)) begin n_fail++; $display("FAIL hour_inc_dec: got %h required %h", time_set, mk(23, 48, 0)); end
        press(0, 0, 0, 1);
        n_cmp++; if (editing !== 1'b0) begin n_fail++; $display("FAIL hour_cancel: got editing=%b required 0", editing); end
    endtask

    task automatic test_min_sec_wrap();
        time_cur = mk(5, 59, 0);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        n_cmp++; if (field_sel !== 2'b10) begin n_fail++; $display("FAIL min_field: got %b required 10", field_sel); end
        press(0, 1, 0, 0);
        n_cmp++; if (time_set !== mk(5, 0, 0)) begin n_fail++; $display("FAIL min_inc_wrap: got %h required %h", time_set, mk(5, 0, 0)); end
        press(1, 0, 0, 0);
        n_cmp++; if (field_sel !== 2'b11) begin n_fail++; $display("FAIL sec_field: got %b required 11", field_sel); end
        press(0, 0, 1, 0);
        n_cmp++; if (time_set !== mk(5, 0, 59)) begin n_fail++; $display("FAIL sec_dec_wrap: got %h required %h", time_set, mk(5, 0, 59)); end
        press(0, 0, 0, 1);
    endtask

    task automatic test_full_commit();
        int s0;
        time_cur = mk(23, 48, 0);
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        n_cmp++; if (time_set !== mk(0, 49, 0)) begin n_fail++; $display("FAIL commit_pre: got %h required %h", time_set, mk(0, 49, 0)); end
        s0 = strobe_cnt;
        exp_q.push_back(mk(0, 49, 0));
        press(1, 0, 0, 0);
        n_cmp++; if (time_ow !== 1'b1) begin n_fail++; $display("FAIL commit_ow: got %b required 1", time_ow); end
        n_cmp++; if (editing !== 1'b0) begin n_fail++; $display("FAIL commit_editing: got %b required 0", editing); end
        @(negedge clk);
        n_cmp++; if (time_ow !== 1'b0) begin n_fail++; $display("FAIL commit_ow_len: got %b required 0", time_ow); end
        n_cmp++; if (field_sel !== 2'b00) begin n_fail++; $display("FAIL commit_idle_field: got %b required 00", field_sel); end
        n_cmp++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL commit_idle_state: got %0d required 0", state_dbg); end
        n_cmp++; if (time_set !== mk(0, 49, 0)) begin n_fail++; $display("FAIL commit_hold: got %h required %h", time_set, mk(0, 49, 0)); end
        n_cmp++; if (strobe_cnt !== s0 + 1) begin n_fail++; $display("FAIL commit_count: got %0d required %0d", strobe_cnt, s0 + 1); end
    endtask

    task automatic test_cancel_and_idle();
        int s0;
        s0 = strobe_cnt;
        time_cur = mk(7, 30, 15);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        press(1, 1, 0, 1);
        n_cmp++; if (editing !== 1'b0) begin n_fail++; $display("FAIL cancel_editing: got %b required 0", editing); end
        n_cmp++; if (time_ow !== 1'b0) begin n_fail++; $display("FAIL cancel_ow: got %b required 0", time_ow); end
        n_cmp++; if (time_set !== mk(7, 30, 15)) begin n_fail++; $display("FAIL cancel_no_step: got %h required %h", time_set, mk(7, 30, 15)); end
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        press(0, 0, 0, 1);
        n_cmp++; if (editing !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_edit: got %b required 0", editing); end
        n_cmp++; if (time_set !== mk(7, 30, 15)) begin n_fail++; $display("FAIL idle_ignore_time: got %h required %h", time_set, mk(7, 30, 15)); end
        n_cmp++; if (strobe_cnt !== s0) begin n_fail++; $display("FAIL cancel_strobes: got %0d required %0d", strobe_cnt, s0); end
    endtask

    task automatic test_reset_mid_edit();
        int s0;
        s0 = strobe_cnt;
        time_cur = mk(12, 34, 56);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        rst = 1'b1;
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        n_cmp++; if ({time_set, time_ow, editing, field_sel} !== 21'd0) begin n_fail++; $display("FAIL rst_mid: got set=%h ow=%b ed=%b fs=%b required all 0", time_set, time_ow, editing, field_sel); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (strobe_cnt !== s0) begin n_fail++; $display("FAIL rst_mid_strobes: got %0d required %0d", strobe_cnt, s0); end
    endtask

    task automatic test_out_of_range();
        time_cur = {5'd31, 6'd60, 6'd60};
        press(1, 0, 0, 0);
        n_cmp++; if (time_set !== 17'd0) begin n_fail++; $display("FAIL oor_all: got %h required 0", time_set); end
        press(0, 0, 0, 1);
        time_cur = {5'd24, 6'd30, 6'd63};
        press(1, 0, 0, 0);
        n_cmp++; if (time_set !== mk(0, 30, 0)) begin n_fail++; $display("FAIL oor_mixed: got %h required %h", time_set, mk(0, 30, 0)); end
        press(0, 0, 0, 1);
    endtask

    task automatic test_mode_beats_step();
        time_cur = mk(10, 20, 30);
        press(1, 0, 0, 0);
        press(1, 1, 0, 0);
        n_cmp++; if (field_sel !== 2'b10) begin n_fail++; $display("FAIL mode_inc_field: got %b required 10", field_sel); end
        n_cmp++; if (time_set !== mk(10, 20, 30)) begin n_fail++; $display("FAIL mode_inc_time: got %h required %h", time_set, mk(10, 20, 30)); end
        press(1, 0, 1, 0);
        n_cmp++; if (time_set !== mk(10, 20, 30)) begin n_fail++; $display("FAIL mode_dec_time: got %h required %h", time_set, mk(10, 20, 30)); end
        press(0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        int h, m, s, n, op, s0;
        s0 = strobe_cnt;
        for (int it = 0; it < 8; it++) begin
            h = $urandom_range(0, 23);
            m = $urandom_range(0, 59);
            s = $urandom_range(0, 59);
            if (it == 0) begin h = 0; m = 59; s = 0; end
            time_cur = mk(h, m, s);
            press(1, 0, 0, 0);
            for (int f = 1; f <= 3; f++) begin
                n = $urandom_range(0, 5);
                for (int k = 0; k < n; k++) begin
                    op = $urandom_range(0, 2);
                    if (op == 0) begin
                        if (f == 1) h = (h == 23) ? 0 : h + 1;
                        if (f == 2) m = (m == 59) ? 0 : m + 1;
                        if (f == 3) s = (s == 59) ? 0 : s + 1;
                    end else if (op == 1) begin
                        if (f == 1) h = (h == 0) ? 23 : h - 1;
                        if (f == 2) m = (m == 0) ? 59 : m - 1;
                        if (f == 3) s = (s == 0) ? 59 : s - 1;
                    end
                    press(0, op != 1, op != 0, 0);
                    n_cmp++; if (time_set !== mk(h, m, s) || field_sel !== 2'(f)) begin n_fail++; $display("FAIL b2b_step: got %h/%b required %h/%b", time_set, field_sel, mk(h, m, s), 2'(f)); end
                end
                if (f == 3) exp_q.push_back(mk(h, m, s));
                press(1, 0, 0, 0);
            end
            n_cmp++; if (time_ow !== 1'b1) begin n_fail++; $display("FAIL b2b_ow: got %b required 1", time_ow); end
            @(negedge clk);
        end
        n_cmp++; if (strobe_cnt !== s0 + 8 || exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_count: got %0d strobes required %0d", strobe_cnt - s0, 8); end
    endtask

`ifdef EDIT_TIMEOUT_EN
    task automatic test_timeout();
        int s0;
        s0 = strobe_cnt;
        time_cur = mk(1, 2, 3);
        press(1, 0, 0, 0);
        repeat (15) @(negedge clk);
        n_cmp++; if (editing !== 1'b1) begin n_fail++; $display("FAIL to_early: got editing=%b required 1", editing); end
        @(negedge clk);
        n_cmp++; if (editing !== 1'b0) begin n_fail++; $display("FAIL to_expire: got editing=%b required 0", editing); end
        press(1, 0, 0, 0);
        repeat (9) @(negedge clk);
        press(0, 1, 0, 0);
        repeat (15) @(negedge clk);
        n_cmp++; if (editing !== 1'b1) begin n_fail++; $display("FAIL to_restart: got editing=%b required 1", editing); end
        @(negedge clk);
        n_cmp++; if (editing !== 1'b0) begin n_fail++; $display("FAIL to_restart_expire: got editing=%b required 0", editing); end
        n_cmp++; if (strobe_cnt !== s0) begin n_fail++; $display("FAIL to_strobes: got %0d required %0d", strobe_cnt, s0); end
    endtask
`endif

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_capture_and_hour_wrap();
        test_min_sec_wrap();
        test_full_commit();
        test_cancel_and_idle();
        test_reset_mid_edit();
        test_out_of_range();
        test_mode_beats_step();
        test_back_to_back();
`ifdef EDIT_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
